// File: rtl/ccip_txn_tracker.sv
// Request/response transaction tracker: per-channel tag slots with ages,
// duplicate/orphan/timeout detection and a first-word fall-through event FIFO.
module ccip_txn_tracker #(
  parameter int NUM_CH         = 2,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LOG_DEPTH      = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          sys_reset,
  input  logic                          enable_tracker,
  input  logic                          clear,
  input  logic [NUM_CH-1:0]             req_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]   req_tag,
  input  logic [NUM_CH-1:0]             rsp_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]   rsp_tag,
  output logic [NUM_CH*CNT_WIDTH-1:0]   outstanding,
  output logic [2:0]                    err_sticky,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [TAG_WIDTH+3:0]          evt_data,
  output logic [CNT_WIDTH-1:0]          drop_cnt
);

  localparam int NUM_SLOTS = 1 << TAG_WIDTH;
  localparam int AGE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EVT_W     = TAG_WIDTH + 4;
  localparam int PTR_W     = $clog2(LOG_DEPTH);
  localparam int NEVT_W    = $clog2(NUM_CH * NUM_SLOTS + 1);

  localparam logic [AGE_W-1:0]     AGE_LIMIT = AGE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AGE_W-1:0]     AGE_ONE   = AGE_W'(1);
  localparam logic [TAG_WIDTH:0]   DEC_ONE   = (TAG_WIDTH + 1)'(1);
  localparam logic [CNT_WIDTH:0]   OUT_MAX   = (CNT_WIDTH + 1)'(NUM_SLOTS);
  localparam logic [PTR_W:0]       PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [1:0]           EVT_DUP   = 2'b01;
  localparam logic [1:0]           EVT_ORPH  = 2'b10;
  localparam logic [1:0]           EVT_TMO   = 2'b11;

  logic [NUM_CH-1:0][NUM_SLOTS-1:0]            busy_q, busy_d;
  logic [NUM_CH-1:0][NUM_SLOTS-1:0][AGE_W-1:0] age_q, age_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]            out_q, out_d;
  logic [2:0]                                  err_q, err_d;
  logic [CNT_WIDTH-1:0]                        drop_q, drop_d;
  logic [PTR_W:0]                              wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]                              rd_ptr_q, rd_ptr_d;
  logic [EVT_W-1:0]                            mem_q [LOG_DEPTH];
  logic [EVT_W-1:0]                            mem_d [LOG_DEPTH];

  logic [NUM_CH-1:0][NUM_SLOTS-1:0] tmo_hit, dup_hit, orph_hit;
  logic                             found_tmo, found_dup, found_orph;
  logic [EVT_W-1:0]                 evt_tmo, evt_dup, evt_orph, evt_new;
  logic                             evt_raised;
  logic [NEVT_W-1:0]                n_evt, n_drop;
  logic                             fifo_empty, fifo_full, pop, push;
  logic [CNT_WIDTH:0]               drop_sum;
  logic                             active;

  assign active = enable_tracker && !clear;

  // Slot tracking: allocate, retire, age and time out each channel/tag slot.
  always_comb begin
    logic              rq, rs, aged, inc;
    logic [TAG_WIDTH:0] dec;
    logic [CNT_WIDTH:0] up, dn;
    busy_d   = busy_q;
    age_d    = age_q;
    out_d    = out_q;
    tmo_hit  = '0;
    dup_hit  = '0;
    orph_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      inc = 1'b0;
      dec = '0;
      for (int t = 0; t < NUM_SLOTS; t++) begin
        rq   = active && req_valid[c] && (req_tag[c*TAG_WIDTH +: TAG_WIDTH] == TAG_WIDTH'(t));
        rs   = active && rsp_valid[c] && (rsp_tag[c*TAG_WIDTH +: TAG_WIDTH] == TAG_WIDTH'(t));
        aged = busy_q[c][t] && (age_q[c][t] == AGE_LIMIT);
        if (active) begin
          if (busy_q[c][t]) begin
            if (rq && rs) begin
              age_d[c][t] = '0;
            end else if (rs) begin
              busy_d[c][t] = 1'b0;
              dec = dec + DEC_ONE;
            end else if (aged) begin
              // A request landing on an expiring slot reallocates the freed slot.
              tmo_hit[c][t] = 1'b1;
              if (rq) begin
                age_d[c][t] = '0;
              end else begin
                busy_d[c][t] = 1'b0;
                dec = dec + DEC_ONE;
              end
            end else if (rq) begin
              dup_hit[c][t] = 1'b1;
              age_d[c][t]   = '0;
            end else begin
              age_d[c][t] = age_q[c][t] + AGE_ONE;
            end
          end else begin
            if (rs) orph_hit[c][t] = 1'b1;
            if (rq) begin
              busy_d[c][t] = 1'b1;
              age_d[c][t]  = '0;
              inc = 1'b1;
            end
          end
        end
      end
      up = {1'b0, out_q[c]} + (CNT_WIDTH + 1)'(inc);
      dn = (CNT_WIDTH + 1)'(dec);
      if (up <= dn) begin
        out_d[c] = '0;
      end else begin
        up = up - dn;
        if (up > OUT_MAX) up = OUT_MAX;
        out_d[c] = up[CNT_WIDTH-1:0];
      end
    end
    if (clear) begin
      busy_d = '0;
      age_d  = '0;
      out_d  = '0;
    end
  end

  // Pick the single event to enqueue and count everything raised this cycle.
  always_comb begin
    found_tmo  = 1'b0;
    found_dup  = 1'b0;
    found_orph = 1'b0;
    evt_tmo    = '0;
    evt_dup    = '0;
    evt_orph   = '0;
    n_evt      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int t = 0; t < NUM_SLOTS; t++) begin
        if (tmo_hit[c][t] && !found_tmo) begin
          found_tmo = 1'b1;
          evt_tmo   = {EVT_TMO, 2'(c), TAG_WIDTH'(t)};
        end
        if (dup_hit[c][t] && !found_dup) begin
          found_dup = 1'b1;
          evt_dup   = {EVT_DUP, 2'(c), TAG_WIDTH'(t)};
        end
        if (orph_hit[c][t] && !found_orph) begin
          found_orph = 1'b1;
          evt_orph   = {EVT_ORPH, 2'(c), TAG_WIDTH'(t)};
        end
        n_evt = n_evt + NEVT_W'(tmo_hit[c][t]) + NEVT_W'(dup_hit[c][t])
                      + NEVT_W'(orph_hit[c][t]);
      end
    end
    evt_raised = found_tmo || found_dup || found_orph;
    evt_new    = found_tmo ? evt_tmo : (found_dup ? evt_dup : evt_orph);
  end

  // Event FIFO push/pop, drop counting and sticky error flags.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop        = !fifo_empty && evt_ready;
    // A full FIFO still accepts the push when the head leaves the same cycle.
    push       = evt_raised && (!fifo_full || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = evt_new;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    n_drop   = n_evt - NEVT_W'(push);
    drop_sum = {1'b0, drop_q} + (CNT_WIDTH + 1)'(n_drop);
    if (clear) begin
      drop_d = '0;
      err_d  = '0;
    end else begin
      drop_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
      err_d  = err_q | {found_tmo, found_orph, found_dup};
    end
  end

  // State registers; reset wipes tracking, counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      busy_q   <= '0;
      age_q    <= '0;
      out_q    <= '0;
      err_q    <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      busy_q   <= busy_d;
      age_q    <= age_d;
      out_q    <= out_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign outstanding = out_q;
  assign err_sticky  = err_q;
  assign drop_cnt    = drop_q;
  assign evt_valid   = !fifo_empty;
  assign evt_data    = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: tb/tb_ccip_txn_tracker.sv
// Directed bench for ccip_txn_tracker with an expected-event scoreboard.
module tb_ccip_txn_tracker;
  localparam int NUM_CH = 2, TAG_WIDTH = 4, TIMEOUT_CYCLES = 16, LOG_DEPTH = 8, CNT_WIDTH = 16;

  logic        clk = 1'b0;
  logic        sys_reset, enable_tracker, clear;
  logic [1:0]  req_valid, rsp_valid;
  logic [7:0]  req_tag, rsp_tag;
  logic [31:0] outstanding;
  logic [2:0]  err_sticky;
  logic        evt_valid, evt_ready;
  logic [7:0]  evt_data;
  logic [15:0] drop_cnt;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  ccip_txn_tracker #(
    .NUM_CH(NUM_CH), .TAG_WIDTH(TAG_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .LOG_DEPTH(LOG_DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .sys_reset(sys_reset), .enable_tracker(enable_tracker), .clear(clear),
    .req_valid(req_valid), .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
    .outstanding(outstanding), .err_sticky(err_sticky), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_data(evt_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    rsp_valid = '0;
    req_tag   = '0;
    rsp_tag   = '0;
  endtask

  task automatic set_req(input int ch, input logic [3:0] tag);
    req_valid[ch]       = 1'b1;
    req_tag[ch*4 +: 4]  = tag;
  endtask

  task automatic set_rsp(input int ch, input logic [3:0] tag);
    rsp_valid[ch]       = 1'b1;
    rsp_tag[ch*4 +: 4]  = tag;
  endtask

  function automatic logic [7:0] evt(input logic [1:0] ty, input logic [1:0] ch, input logic [3:0] tag);
    return {ty, ch, tag};
  endfunction

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Pop events with ready high and compare each against the scoreboard.
  task automatic drain();
    int budget;
    budget = 40;
    evt_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      if (evt_valid) chk("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
      tick();
      budget--;
    end
    evt_ready = 1'b0;
    if (exp_q.size() != 0) begin
      chk("drain_budget", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    chk("no_extra_evt", 32'(evt_valid), 32'd0);
  endtask

  initial begin
    idle();
    enable_tracker = 1'b1;
    clear     = 1'b0;
    evt_ready = 1'b0;
    sys_reset = 1'b1;
    tick(); tick();
    sys_reset = 1'b0;
    chk("rst_outstanding", outstanding, 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Request then response on ch0 tag3.
    set_req(0, 4'd3);
    tick(); idle();
    chk("t1_out_after_req", 32'(outstanding[15:0]), 32'd1);
    repeat (4) tick();
    set_rsp(0, 4'd3);
    tick(); idle();
    chk("t1_out_after_rsp", 32'(outstanding[15:0]), 32'd0);
    chk("t1_no_evt", 32'(evt_valid), 32'd0);

    // Duplicate request on ch1 tag5.
    set_req(1, 4'd5);
    tick(); idle();
    set_req(1, 4'd5);
    exp_q.push_back(evt(2'b01, 2'd1, 4'd5));
    tick(); idle();
    chk("t2_err", 32'(err_sticky), 32'b001);
    chk("t2_out1", 32'(outstanding[31:16]), 32'd1);
    set_rsp(1, 4'd5);
    tick(); idle();
    chk("t2_out1_retired", 32'(outstanding[31:16]), 32'd0);
    drain();
    do_clear();
    chk("t2_err_cleared", 32'(err_sticky), 32'd0);

    // Timeout on ch0 tag0, then a late response becomes an orphan.
    set_req(0, 4'd0);
    exp_q.push_back(evt(2'b11, 2'd0, 4'd0));
    tick(); idle();
    repeat (15) tick();
    chk("t3_no_evt_before_tmo", 32'(evt_valid), 32'd0);
    chk("t3_out_before_tmo", 32'(outstanding[15:0]), 32'd1);
    tick();
    chk("t3_tmo_valid", 32'(evt_valid), 32'd1);
    chk("t3_tmo_data", 32'(evt_data), 32'hC0);
    chk("t3_out_after_tmo", 32'(outstanding[15:0]), 32'd0);
    chk("t3_err_tmo", 32'(err_sticky), 32'b100);
    repeat (3) tick();
    set_rsp(0, 4'd0);
    exp_q.push_back(evt(2'b10, 2'd0, 4'd0));
    tick(); idle();
    chk("t3_err_orph", 32'(err_sticky), 32'b110);
    drain();
    do_clear();

    // Response wins over a same-cycle timeout.
    set_req(0, 4'd8);
    tick(); idle();
    repeat (15) tick();
    set_rsp(0, 4'd8);
    tick(); idle();
    chk("t4_rsp_beats_tmo_out", 32'(outstanding[15:0]), 32'd0);
    chk("t4_rsp_beats_tmo_evt", 32'(evt_valid), 32'd0);
    chk("t4_rsp_beats_tmo_err", 32'(err_sticky), 32'd0);

    // Same-cycle request and response: busy slot reallocates, free slot is orphan+alloc.
    set_req(0, 4'd6);
    tick(); idle();
    set_req(0, 4'd6); set_rsp(0, 4'd6);
    tick(); idle();
    chk("t5_busy_same_out", 32'(outstanding[15:0]), 32'd1);
    chk("t5_busy_same_evt", 32'(evt_valid), 32'd0);
    set_req(1, 4'd9); set_rsp(1, 4'd9);
    exp_q.push_back(evt(2'b10, 2'd1, 4'd9));
    tick(); idle();
    chk("t5_free_same_out", 32'(outstanding[31:16]), 32'd1);
    set_rsp(0, 4'd6); set_rsp(1, 4'd9);
    tick(); idle();
    chk("t5_retire_out", outstanding, 32'd0);
    drain();
    do_clear();

    // Disabled tracker ignores strobes.
    enable_tracker = 1'b0;
    set_req(0, 4'd2);
    tick(); idle();
    enable_tracker = 1'b1;
    chk("t6_disabled_out", 32'(outstanding[15:0]), 32'd0);
    set_rsp(0, 4'd2);
    exp_q.push_back(evt(2'b10, 2'd0, 4'd2));
    tick(); idle();
    drain();
    do_clear();

    // Ten orphans into a depth-8 FIFO with ready low.
    for (int i = 0; i < 10; i++) begin
      idle();
      set_rsp(0, 4'(i));
      if (i < 8) exp_q.push_back(evt(2'b10, 2'd0, 4'(i)));
      tick();
    end
    idle();
    chk("t7_drop", 32'(drop_cnt), 32'd2);
    chk("t7_head_held", 32'(evt_data), 32'h80);
    tick();
    chk("t7_head_still_held", 32'(evt_data), 32'h80);
    drain();
    do_clear();
    chk("t7_drop_cleared", 32'(drop_cnt), 32'd0);

    // Same-cycle orphans on two channels: ch0 wins, ch1 dropped.
    set_rsp(0, 4'd2); set_rsp(1, 4'd2);
    exp_q.push_back(evt(2'b10, 2'd0, 4'd2));
    tick(); idle();
    chk("t8_drop", 32'(drop_cnt), 32'd1);
    chk("t8_err", 32'(err_sticky), 32'b010);
    drain();
    do_clear();

    // Reset mid-operation discards in-flight tags.
    set_req(0, 4'd1); set_req(1, 4'd7);
    tick(); idle();
    set_req(0, 4'd4);
    tick(); idle();
    chk("t9_out_pre_rst", outstanding, {16'd1, 16'd2});
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    chk("t9_out_post_rst", outstanding, 32'd0);
    chk("t9_evt_post_rst", 32'(evt_valid), 32'd0);
    set_rsp(0, 4'd1);
    exp_q.push_back(evt(2'b10, 2'd0, 4'd1));
    tick(); idle();
    set_rsp(1, 4'd7);
    exp_q.push_back(evt(2'b10, 2'd1, 4'd7));
    tick(); idle();
    chk("t9_err_orph", 32'(err_sticky), 32'b010);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/ccip_txn_tracker.md
CCIP_TXN_TRACKER -- requirements
Module: ccip_txn_tracker

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of independent request/response channel pairs, legal range 1..4.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, meaning the number of mdata LSBs used as the tag, giving 2^TAG_WIDTH outstanding slots per channel.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the outstanding age at which a request is declared timed out; must be at least 2.
REQ-004 SHALL have parameter LOG_DEPTH, default 8, meaning the event FIFO depth; must be a power of 2 and at least 2.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, meaning the width of all counters.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port sys_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port enable_tracker, input, 1 bit: when low, requests and responses are ignored, and ages hold.
REQ-009 SHALL have port clear, input, 1 bit: a synchronous pulse with the same effect as reset, except that the event FIFO contents are kept.
REQ-010 SHALL have port req_valid, input, NUM_CH bits: one request strobe per channel.
REQ-011 SHALL have port req_tag, input, NUM_CH*TAG_WIDTH bits: channel c occupies bits [c*TAG_WIDTH +: TAG_WIDTH].
REQ-012 SHALL have port rsp_valid, input, NUM_CH bits: one response strobe per channel.
REQ-013 SHALL have port rsp_tag, input, NUM_CH*TAG_WIDTH bits: packed the same way as req_tag.
REQ-014 SHALL have port outstanding, output, NUM_CH*CNT_WIDTH bits: the per-channel live outstanding count.
REQ-015 SHALL have port err_sticky, output, 3 bits: bit0 duplicate, bit1 orphan, bit2 timeout; bits are set-only until reset or clear.
REQ-016 SHALL have port evt_valid, output, 1 bit, and evt_ready, input, 1 bit: the valid/ready event-FIFO pop handshake.
REQ-017 SHALL have port evt_data, output, 2+2+TAG_WIDTH bits: {type[1:0], ch[1:0], tag}, with type 01 dup, 10 orphan, 11 timeout.
REQ-018 SHALL have port drop_cnt, output, CNT_WIDTH bits: the saturating count of events not enqueued.

Function
REQ-019 SHALL keep one busy bit and one age counter of $clog2(TIMEOUT_CYCLES+1) bits per channel/tag slot.
REQ-020 SHALL, on a request to a free slot, set busy, zero the age and increment outstanding in the next cycle.
REQ-021 SHALL, on a request to a busy slot, raise a duplicate event, leave busy set, restart the age at 0 and leave outstanding unchanged.
REQ-022 SHALL, on a response to a busy slot, clear busy and decrement outstanding.
REQ-023 SHALL, on a response to a free slot, raise an orphan event and change no state.
REQ-024 SHALL treat a same-cycle request and response on the same channel and tag as follows: if the slot is busy, retire it and reallocate it with age 0, with outstanding unchanged and no event; if the slot is free, raise an orphan event and allocate the slot.
REQ-025 SHALL increment the age of every busy slot by 1 per enabled cycle.
REQ-026 SHALL, when an age equals TIMEOUT_CYCLES-1 with no retiring response that cycle, raise a timeout event, free the slot and decrement outstanding.
REQ-027 SHALL treat a later response to a timed-out tag as an orphan.
REQ-028 SHALL give a retiring response priority over a timeout in the same cycle, with no event raised.
REQ-029 SHALL enqueue at most 1 event per cycle, chosen by priority: timeout over duplicate over orphan, then lowest channel, then lowest tag.
REQ-030 SHALL add every other event raised that cycle to drop_cnt.
REQ-031 SHALL, on a push while the FIFO is full, discard the new event and increment drop_cnt, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-032 SHALL saturate drop_cnt at all-ones.
REQ-033 SHALL saturate each outstanding count at 0 and at 2^TAG_WIDTH, which it cannot exceed by construction.
REQ-034 SHALL set err_sticky bits for every raised event, whether that event is enqueued or dropped.
REQ-035 SHALL drive evt_data from the FIFO head, first-word fall-through.
REQ-036 SHALL assert evt_valid exactly when the FIFO is non-empty.
REQ-037 SHALL hold evt_data stable while evt_valid is high and evt_ready is low.
REQ-038 SHALL update outstanding, err_sticky and the FIFO 1 cycle after the input strobe, with no combinational path from inputs to outputs except evt_valid and evt_data from FIFO state.

Reset
REQ-039 SHALL, while sys_reset=1, clear all busy bits, ages, outstanding counts, err_sticky, drop_cnt and FIFO pointers, with evt_valid=0.
REQ-040 SHALL give sys_reset priority over clear, enable_tracker and all strobes.
REQ-041 SHALL, when reset is asserted mid-operation, discard in-flight tags so that their later responses are orphans.
REQ-042 SHALL, on clear, act as reset for tracking state, err_sticky and drop_cnt only.

Verification
REQ-043 SHALL cover: request ch0 tag 3, then response ch0 tag 3 after 5 cycles -> outstanding[0] goes 0, 1, 0, with no event.
REQ-044 SHALL cover: request ch1 tag 5 twice -> event {01,1,5}, err_sticky=001, outstanding[1]=1.
REQ-045 SHALL cover: with TIMEOUT_CYCLES=16, request ch0 tag 0 and no response -> timeout event {11,0,0} on the 16th cycle after the request; a response on the 20th cycle -> orphan event {10,0,0}.
REQ-046 SHALL cover: with evt_ready=0 and LOG_DEPTH=8, ten orphan events -> 8 events queued, drop_cnt=2, and evt_data holds the first event.
REQ-047 SHALL cover: same-cycle orphan responses on ch0 and ch1 -> ch0's event is enqueued and drop_cnt=1.
REQ-048 SHALL cover: 3 tags outstanding, then a sys_reset pulse -> outstanding=0, evt_valid=0, and subsequent responses produce orphan events.
